cpu_fetch_unit: RTL and testbench

- Owns the program counter and the instruction-ROM request/response side of the core.
- Consumes the redirect controls (pc write-enable, target, increment) produced by the control unit.
- Supplies the control unit with the 16-bit instruction word and its PC.
- Holds one instruction at a time with a valid/ready handshake; the ROM may respond with variable latency.

---
 rtl/cpu_fetch_unit_pkg.sv | 11 +
 rtl/cpu_fetch_unit_if.sv | 32 +++
 rtl/cpu_fetch_unit.sv | 86 ++++++++
 tb/tb_cpu_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_unit_pkg.sv
// cpu_fetch_unit_pkg: fetch-state encodings plus the address-width and reset-PC defaults
// shared by the fetch unit and anything that decodes its state.
package cpu_fetch_unit_pkg;
   localparam int          ADDR_W_DEF   = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/cpu_fetch_unit_if.sv
// cpu_fetch_unit_if: ROM request/response and control-unit handshake of the fetch unit.
// o_halted exists only when CPU_FETCH_HALT_DETECT_EN is defined.
interface cpu_fetch_unit_if #(parameter int ADDR_W = 16);
   logic              o_rom_req;
   logic [ADDR_W-1:0] o_rom_addr;
   logic              i_rom_valid;
   logic [15:0]       i_rom_data;
   logic [15:0]       o_instr;
   logic              o_instr_valid;
   logic              i_instr_ready;
   logic [ADDR_W-1:0] o_pc;
   logic              i_pc_we;
   logic [ADDR_W-1:0] i_pc;
   logic              i_pc_increment;
`ifdef CPU_FETCH_HALT_DETECT_EN
   logic              o_halted;
`endif
   modport master (
`ifdef CPU_FETCH_HALT_DETECT_EN
      output o_halted,
`endif
      output o_rom_req, o_rom_addr, o_instr, o_instr_valid, o_pc,
      input  i_rom_valid, i_rom_data, i_instr_ready, i_pc_we, i_pc, i_pc_increment
   );
   modport slave (
`ifdef CPU_FETCH_HALT_DETECT_EN
      input  o_halted,
`endif
      input  o_rom_req, o_rom_addr, o_instr, o_instr_valid, o_pc,
      output i_rom_valid, i_rom_data, i_instr_ready, i_pc_we, i_pc, i_pc_increment
   );
endinterface

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: program counter and single-outstanding instruction fetch with a one-deep
// valid/ready holding register. CPU_FETCH_HALT_DETECT_EN adds sticky jump-to-self halt detection.
module cpu_fetch_unit
   import cpu_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   cpu_fetch_unit_if.master  bus
);
   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, opc_q, opc_d, next_pc;
   logic [15:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              retire, capture, halt_now, halted_q;

   assign retire  = valid_q && bus.i_instr_ready;
   assign next_pc = bus.i_pc_we ? bus.i_pc : bus.i_pc_increment ? pc_q + 1'b1 : pc_q;
   assign capture = state_q == FETCH_WAIT && bus.i_rom_valid && !halted_q;

   always_comb begin
      state_d = state_q == FETCH_BOOT ? FETCH_WAIT :
                capture               ? FETCH_HOLD :
                retire                ? FETCH_WAIT : state_q;
      pc_d    = retire ? next_pc : pc_q;
      instr_d = capture ? bus.i_rom_data : instr_q;
      opc_d   = capture ? pc_q : opc_q;
      valid_d = capture | (valid_q & ~retire);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= FETCH_BOOT;
         pc_q    <= RESET_PC;
         opc_q   <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         opc_q   <= opc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // BOOT is also the reset state, so its request must stay quiet while reset is held
   assign bus.o_rom_req     = (state_q == FETCH_BOOT && i_rst_n) || (retire && !halt_now);
   assign bus.o_rom_addr    = state_q == FETCH_BOOT ? pc_q : next_pc;
   assign bus.o_instr       = instr_q;
   assign bus.o_instr_valid = valid_q;
   assign bus.o_pc          = opc_q;

`ifdef CPU_FETCH_HALT_DETECT_EN
   logic              prev_seq_q, prev_seq_d, halted_d;
   logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;

   // a jump back onto the previous, sequentially-reached instruction is a terminal loop
   assign halt_now = retire && bus.i_pc_we && prev_seq_q && bus.i_pc == prev_pc_q;

   always_comb begin
      prev_pc_d  = retire ? pc_q : prev_pc_q;
      prev_seq_d = retire ? !bus.i_pc_we && bus.i_pc_increment : prev_seq_q;
      halted_d   = halted_q | halt_now;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_pc_q  <= RESET_PC;
         prev_seq_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         prev_pc_q  <= prev_pc_d;
         prev_seq_q <= prev_seq_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.o_halted = halted_q;
`else
   assign halt_now = 1'b0;
   assign halted_q = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: random ROM latency / ready / redirect stimulus; a fetch-address model
// feeds scoreboard queues that an independent negedge monitor drains and checks.
module tb_cpu_fetch_unit;
   typedef struct packed {logic we; logic inc; logic [15:0] tgt;} dec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   cpu_fetch_unit_if #(.ADDR_W(16)) bus ();
   cpu_fetch_unit dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem [logic [15:0]];
   logic [15:0] exp_req [$];
   logic [31:0] exp_out [$];
   dec_t        ovr [$];

   // stimulus knobs and behavioural model state
   int          p_ready = 100, lat_lo = 1, lat_hi = 1;
   bit          spur_en = 0;
   logic [15:0] mpc, m_prev;
   bit          m_prev_seq, m_halted;

   // monitor-owned ROM/timing state
   int          due = -1, rel = 0, first_req = -1, first_val = -1;
   logic [15:0] raddr, hold_pc, hold_instr;
   bit          prev_v = 0;

   function automatic logic [15:0] rom_word(logic [15:0] a);
      return mem.exists(a) ? mem[a] : (a * 16'h9E37) ^ 16'h3C5A;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push_fetch(logic [15:0] a);
      exp_req.push_back(a);
      exp_out.push_back({a, rom_word(a)});
   endtask

   task automatic retire_model();
      dec_t        d;
      logic [15:0] nxt;
      if (ovr.size() != 0) d = ovr.pop_front();
      else begin
         d.we  = ($urandom % 4) == 0;
         d.inc = ($urandom % 4) != 0;
         case ($urandom % 4)
            0: d.tgt = 16'($urandom);
            1: d.tgt = 16'hFFFF;
            2: d.tgt = mpc;
            default: d.tgt = 16'($urandom % 8);
         endcase
      end
      bus.i_pc_we = d.we;
      bus.i_pc_increment = d.inc;
      bus.i_pc = d.tgt;
      nxt = d.we ? d.tgt : d.inc ? mpc + 16'd1 : mpc;
`ifdef CPU_FETCH_HALT_DETECT_EN
      if (d.we && d.tgt == m_prev && m_prev_seq) m_halted = 1;
      m_prev = mpc;
      m_prev_seq = !d.we && d.inc;
`endif
      mpc = nxt;
      if (!m_halted) push_fetch(nxt);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.i_rom_valid = 1'b0;
      bus.i_rom_data = 16'($urandom);
      if (due == cyc) begin
         bus.i_rom_valid = 1'b1;
         bus.i_rom_data = rom_word(raddr);
      end else if (spur_en && bus.o_instr_valid && ($urandom % 2) == 1) bus.i_rom_valid = 1'b1;
      bus.i_instr_ready = 32'($urandom % 100) < p_ready;
      bus.i_pc_we = 1'($urandom);
      bus.i_pc_increment = 1'($urandom);
      bus.i_pc = 16'($urandom);
      if (bus.o_instr_valid && bus.i_instr_ready) retire_model();
   endtask

   task automatic do_reset(bit stale);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.i_rom_valid = 1'b0;
      bus.i_instr_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_rom_req", 32'(bus.o_rom_req), 32'd0);
      check("rst_valid", 32'(bus.o_instr_valid), 32'd0);
      check("rst_instr", 32'(bus.o_instr), 32'h0);
      check("rst_pc", 32'(bus.o_pc), 32'h0);
      @(posedge clk);
      #1;
      exp_req.delete();
      exp_out.delete();
      mpc = 16'h0000;
      m_prev = 16'h0000;
      m_prev_seq = 0;
      m_halted = 0;
      rst_n = 1'b1;
      push_fetch(16'h0000);
      if (stale) begin
         bus.i_rom_valid = 1'b1;
         bus.i_rom_data = 16'hDEAD;
      end
   endtask

   task automatic wait_valid(string name);
      int n = 0;
      while (!bus.o_instr_valid && n < 20) begin
         step();
         n++;
      end
      if (!bus.o_instr_valid) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         due = -1;
         rel = 0;
         first_req = -1;
         first_val = -1;
         prev_v = 0;
      end else begin
         rel++;
         if (bus.o_rom_req) begin
            if (first_req < 0) first_req = rel;
            if (exp_req.size() == 0) check("unexpected_req", 32'(bus.o_rom_addr), 32'hFFFFFFFF);
            else check("rom_addr", 32'(bus.o_rom_addr), 32'(exp_req.pop_front()));
            due = cyc + lat_lo + int'($urandom % 32'(lat_hi - lat_lo + 1));
            raddr = bus.o_rom_addr;
         end
         if (bus.o_instr_valid && !prev_v) begin
            if (first_val < 0) first_val = rel;
            if (exp_out.size() == 0) check("unexpected_valid", {bus.o_pc, bus.o_instr}, 32'hFFFFFFFF);
            else check("instr_pc", {bus.o_pc, bus.o_instr}, exp_out.pop_front());
            hold_pc = bus.o_pc;
            hold_instr = bus.o_instr;
         end else if (bus.o_instr_valid) begin
            check("hold_instr", 32'(bus.o_instr), 32'(hold_instr));
            check("hold_pc", 32'(bus.o_pc), 32'(hold_pc));
         end
         prev_v = bus.o_instr_valid;
      end
   end

   initial begin
      bus.i_rom_valid = 1'b0;
      bus.i_rom_data = '0;
      bus.i_instr_ready = 1'b0;
      bus.i_pc_we = 1'b0;
      bus.i_pc = '0;
      bus.i_pc_increment = 1'b0;
      mem[16'h0000] = 16'h0005;

      // first fetch timing, wrap at 0xFFFF and pc_we priority over increment
      ovr.push_back('{1'b0, 1'b1, 16'h0000});
      ovr.push_back('{1'b1, 1'b0, 16'hFFFF});
      ovr.push_back('{1'b0, 1'b1, 16'h0000});
      ovr.push_back('{1'b1, 1'b1, 16'h0040});
      do_reset(0);
      for (int i = 0; i < 40 && (ovr.size() != 0 || i < 12); i++) step();
      check("first_req_cycle", 32'(first_req), 32'd1);
      check("first_valid_cycle", 32'(first_val), 32'd3);
      check("ovr_consumed", 32'(ovr.size()), 32'd0);

      // stalled core, 3-cycle ROM, spurious strobes while holding
      p_ready = 0;
      lat_lo = 3;
      lat_hi = 3;
      wait_valid("stall_a");
      p_ready = 100;
      step();
      p_ready = 0;
      spur_en = 1;
      wait_valid("stall_b");
      repeat (6) step();
      check("stall_req_drained", 32'(exp_req.size()), 32'd0);

      // reset while a response is outstanding, stale strobe on release
      p_ready = 100;
      lat_lo = 4;
      lat_hi = 4;
      for (int i = 0; i < 20 && !(!bus.o_instr_valid && due > cyc); i++) step();
      check("reached_wait", 32'(!bus.o_instr_valid && due > cyc), 32'd1);
      lat_lo = 2;
      lat_hi = 2;
      do_reset(1);
      wait_valid("post_reset");
      check("post_reset_instr", 32'(bus.o_instr), 32'h0005);

      // random traffic
      p_ready = 60;
      lat_lo = 1;
      lat_hi = 4;
      repeat (3000) step();
      check("rand_req_drained", 32'(exp_req.size()), 32'd0);

`ifdef CPU_FETCH_HALT_DETECT_EN
      // canonical end-of-program loop: 0,1 sequential then jump back to 1 from 2
      mem[16'h0001] = 16'h1111;
      mem[16'h0002] = 16'h2222;
      p_ready = 100;
      lat_lo = 1;
      lat_hi = 1;
      spur_en = 0;
      ovr.delete();
      ovr.push_back('{1'b0, 1'b1, 16'h0000});
      ovr.push_back('{1'b0, 1'b1, 16'h0000});
      ovr.push_back('{1'b1, 1'b0, 16'h0001});
      do_reset(0);
      check("halted_after_reset", 32'(bus.o_halted), 32'd0);
      repeat (30) step();
      check("halted", 32'(bus.o_halted), 32'd1);
      check("halt_model", 32'(m_halted), 32'd1);
      check("halted_valid", 32'(bus.o_instr_valid), 32'd0);
      check("halted_req", 32'(bus.o_rom_req), 32'd0);
      check("halt_req_drained", 32'(exp_req.size()), 32'd0);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
